cond_sample_packer: RTL

COND_SAMPLE_PACKER -- requirements
Module: cond_sample_packer

---
 rtl/cond_sample_packer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cond_sample_packer.sv
// Packs a qualified byte stream into WORD_BYTES-wide words with a one-entry output register.
// Partial words can be flushed; bytes that cannot be stored are dropped and counted.
module cond_sample_packer #(
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [7:0]              data,
    input  logic                    flush,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic [3:0]              out_count,
    output logic                    overflow,
    output logic [7:0]              drop_count
);

    localparam int unsigned DW        = 8 * WORD_BYTES;
    localparam logic [3:0]  FULL_FILL = 4'(WORD_BYTES);
    localparam logic [3:0]  LAST_FILL = 4'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL
    } state_e;

    state_e          state_c;
    logic [3:0]      fill_q, fill_d;
    logic [DW-1:0]   buf_q, buf_d;
    logic            pend_q, pend_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [3:0]      out_count_q, out_count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_q, drop_d;
    logic            free_c;
    logic            load_c;
    logic            drop_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q      <= '0;
            buf_q       <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            fill_q      <= fill_d;
            buf_q       <= buf_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
        end
    end

    // Pack-buffer state is a function of the fill level
    always_comb begin
        state_c = ST_FILLING;
        if (fill_q == '0) begin
            state_c = ST_EMPTY;
        end else if (fill_q == FULL_FILL) begin
            state_c = ST_FULL;
        end
    end

    // Next-state logic
    always_comb begin
        fill_d      = fill_q;
        buf_d       = buf_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        overflow_d  = overflow_q;
        drop_d      = drop_q;
        load_c      = 1'b0;
        drop_c      = 1'b0;
        free_c      = !out_valid_q || out_ready;

        if (pend_q) begin
            drop_c = en;
            if (free_c) begin
                load_c      = 1'b1;
                out_data_d  = buf_q;
                out_count_d = fill_q;
                buf_d       = '0;
                fill_d      = '0;
                pend_d      = 1'b0;
            end
        end else if (state_c == ST_FULL) begin
            if (free_c) begin
                // Word leaves and a concurrent byte starts the next word in lane 0
                load_c      = 1'b1;
                out_data_d  = buf_q;
                out_count_d = FULL_FILL;
                buf_d       = en ? DW'(data) : '0;
                fill_d      = en ? 4'd1 : 4'd0;
            end else begin
                drop_c = en;
            end
            if (flush && (!free_c || en)) begin
                pend_d = 1'b1;
            end
        end else begin
            if (en) begin
                if (fill_q == LAST_FILL && free_c) begin
                    load_c                       = 1'b1;
                    out_data_d                   = buf_q;
                    out_data_d[8*(WORD_BYTES-1) +: 8] = data;
                    out_count_d                  = FULL_FILL;
                    buf_d                        = '0;
                    fill_d                       = '0;
                end else begin
                    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                        if (fill_q == 4'(i)) begin
                            buf_d[8*i +: 8] = data;
                        end
                    end
                    fill_d = fill_q + 4'd1;
                end
            end
            if (flush && (en ? !(fill_q == LAST_FILL && free_c) : (state_c != ST_EMPTY))) begin
                pend_d = 1'b1;
            end
        end

        if (load_c) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (drop_c) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_count  = out_count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule
